booth_control: RTL and testbench
================================

Name: booth_control

Overview:
- Control unit for the radix-2 Booth multiplier datapath. It sits directly upstream of that datapath.
- Accepts a multiply request and issues the load/subtract/shift control sequence from the datapath's q(0),q(-1) feedback.
- Captures the final 2N-bit product and holds it under a done/ack handshake for the consumer.
- One controller per datapath instance.

Parameters:
- N, 3, operand width in bits; also the number of Booth iterations.
- CNT_W, 2, iteration counter width; must hold N, i.e. CNT_W = clog2(N+1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- inicio  input  1  multiply request; sampled only in IDLE.
- q  input  2  datapath feedback {q(0), q(-1)}.
- resultado  input  2N  datapath {A,Q} concatenation (product once iterations complete).
- ack  input  1  consumer acknowledge of producto.
- start  output  1  datapath load strobe (load Q and M, clear A).
- resta  output  1  adder mode; 1 = A-M, 0 = A+M.
- carga_a  output  1  write adder result into A.
- desp  output  1  arithmetic right shift of A:Q:q(-1).
- ocupado  output  1  high in every state except IDLE.
- fin  output  1  product valid.
- producto  output  2N  registered product.

Behaviour:
- States: IDLE, LOAD, EVAL, SHIFT, CAPTURE, WAIT_ACK. The state register and counter are the only sequential control.
- Control outputs are combinational decodes of state; EVAL also decodes q. fin and producto are registered.
- Reset (rst_n=0 at an edge): state=IDLE, counter=0, producto=0, fin=0.
  - All combinational outputs are 0 in IDLE.
  - Reset mid-operation aborts immediately; no partial product is captured.
- IDLE: inicio=1 -> LOAD; otherwise stay.
- LOAD: start=1 for exactly one cycle; counter <= N; -> EVAL.
- EVAL (q decode):
  - q=01: carga_a=1, resta=0.
  - q=10: carga_a=1, resta=1.
  - q=00 or 11: carga_a=0, resta=0.
  - Always -> SHIFT.
- SHIFT: desp=1; counter <= counter-1.
  - If counter==1 -> CAPTURE; else -> EVAL.
- CAPTURE: producto <= resultado; fin <= 1; -> WAIT_ACK.
- WAIT_ACK: fin=1 and producto held. ack=1 -> fin<=0, IDLE.
- Timing:
  - Edge 0 is the edge that samples inicio=1.
  - Each iteration takes exactly 2 cycles (EVAL, SHIFT).
  - fin is first high after edge 2N+2 (edge 8 for N=3).
  - Earliest next accept is one cycle after ack.
- Invariants:
  - resta is never 1 while carga_a=0.
  - start, carga_a and desp are mutually exclusive.
  - carga_a and desp are never both 1 in the same cycle.
- Boundary rules:
  - inicio outside IDLE is ignored.
  - ack outside WAIT_ACK is ignored.
  - inicio and ack both high in WAIT_ACK: go to IDLE only; the request must be re-presented.
  - producto keeps its last value until the next CAPTURE, including across IDLE.
  - The counter never wraps: decrement occurs only in SHIFT with counter>=1.

Decomposition:
- booth_pkg holds:
  - the state encoding (6 states, 3-bit enum);
  - Booth pair constants Q_ADD=2'b01 and Q_SUB=2'b10;
  - the default N.
- One natural sub-module: booth_contador. It is a loadable down-counter with terminal flag (load N, dec, last = count==1).
- The FSM and output register stay in booth_control.

Test Plan:
1. Reset mid-run: assert rst_n=0 during the second EVAL -> next edge state=IDLE, ocupado=0, fin=0, producto=0, all controls 0.
2. Control trace: with q forced to 10, 11, 01 on the three EVALs:
   - carga_a/resta = 1/1, 0/0, 1/0;
   - desp pulses on cycles 3, 5, 7 after edge 0;
   - start exactly once on cycle 1.
3. Closed loop with a behavioural Booth datapath model, multiplicando=3, multiplicador=-2 -> producto=6'b111010 (-6), fin high after edge 8.
4. Closed loop, multiplicando=-4, multiplicador=-4 -> producto=6'b010000 (+16); multiplicando=3, multiplicador=3 -> 6'b001001.
5. Handshake:
   - hold ack=0 for 10 cycles -> fin and producto stable;
   - ack with inicio both high -> IDLE, no new LOAD;
   - inicio next cycle -> LOAD.
6. Spurious inputs: inicio pulses during EVAL/SHIFT and ack pulses in IDLE -> no state, counter or producto change.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth controller: state encoding, Booth pair codes, default width.
package booth_pkg;

    localparam int BOOTH_N = 3;

    localparam logic [1:0] Q_ADD = 2'b01;
    localparam logic [1:0] Q_SUB = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_EVAL     = 3'd2,
        ST_SHIFT    = 3'd3,
        ST_CAPTURE  = 3'd4,
        ST_WAIT_ACK = 3'd5
    } state_t;

endpackage

// File: rtl/booth_contador.sv
// Loadable iteration down-counter; o_last flags the final iteration (count==1), one cycle latency.
// Decrement saturates at zero so the count can never wrap.
module booth_contador #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_last
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_last = (r_count == CNT_W'(1));

endmodule

// File: rtl/booth_control.sv
// Booth multiplier sequencer: LOAD, N x (EVAL, SHIFT), CAPTURE, then holds producto with fin until ack.
// Product valid 2N+2 edges after the request is accepted; no new request is taken until ack.
module booth_control
    import booth_pkg::*;
#(
    parameter int N     = BOOTH_N,
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           inicio,
    input  logic [1:0]     q,
    input  logic [2*N-1:0] resultado,
    input  logic           ack,
    output logic           start,
    output logic           resta,
    output logic           carga_a,
    output logic           desp,
    output logic           ocupado,
    output logic           fin,
    output logic [2*N-1:0] producto
);

    state_t         r_state;
    logic           r_fin;
    logic [2*N-1:0] r_producto;
    logic           w_last;

    booth_contador #(
        .CNT_W (CNT_W)
    ) u_contador (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (r_state == ST_LOAD),
        .i_load_val (CNT_W'(N)),
        .i_dec      (r_state == ST_SHIFT),
        .o_last     (w_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_fin      <= 1'b0;
            r_producto <= '0;
        end else begin
            case (r_state)
                ST_IDLE:     if (inicio) r_state <= ST_LOAD;
                ST_LOAD:     r_state <= ST_EVAL;
                ST_EVAL:     r_state <= ST_SHIFT;
                ST_SHIFT:    r_state <= w_last ? ST_CAPTURE : ST_EVAL;
                ST_CAPTURE: begin
                    r_producto <= resultado;
                    r_fin      <= 1'b1;
                    r_state    <= ST_WAIT_ACK;
                end
                // A request arriving together with ack is dropped; it must be re-presented from IDLE.
                ST_WAIT_ACK: begin
                    if (ack) begin
                        r_fin   <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default:     r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        start   = 1'b0;
        resta   = 1'b0;
        carga_a = 1'b0;
        desp    = 1'b0;
        ocupado = (r_state != ST_IDLE);
        case (r_state)
            ST_LOAD:  start = 1'b1;
            ST_EVAL: begin
                carga_a = (q == Q_ADD) || (q == Q_SUB);
                resta   = (q == Q_SUB);
            end
            ST_SHIFT: desp = 1'b1;
            default:  ;
        endcase
    end

    assign fin      = r_fin;
    assign producto = r_producto;

endmodule

// File: tb/tb_booth_control.sv
// Directed + randomized bench for booth_control, closed around a behavioural Booth datapath.
module tb_booth_control;

    localparam int N     = 3;
    localparam int CNT_W = 2;

    logic           clk = 1'b0;
    logic           rst_n, inicio, ack;
    logic [1:0]     q, q_force;
    logic [2*N-1:0] resultado;
    logic           start, resta, carga_a, desp, ocupado, fin;
    logic [2*N-1:0] producto;
    logic [5:0]     ctl;

    int             n_pass = 0;
    int             n_total = 0;
    bit             use_model;
    int             op_a, op_b;
    logic [2*N-1:0] exp_prod;

    // Datapath model: accumulator kept wider than N so A-M never overflows.
    int signed      dp_a;
    logic [N-1:0]   dp_q;
    logic           dp_q1;
    int signed      dp_m;

    booth_control #(.N(N), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inicio    (inicio),
        .q         (q),
        .resultado (resultado),
        .ack       (ack),
        .start     (start),
        .resta     (resta),
        .carga_a   (carga_a),
        .desp      (desp),
        .ocupado   (ocupado),
        .fin       (fin),
        .producto  (producto)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (start) begin
            dp_a  <= 0;
            dp_q  <= op_b[N-1:0];
            dp_q1 <= 1'b0;
            dp_m  <= op_a;
        end else if (carga_a) begin
            dp_a <= resta ? dp_a - dp_m : dp_a + dp_m;
        end else if (desp) begin
            dp_a  <= dp_a >>> 1;
            dp_q  <= {dp_a[0], dp_q[N-1:1]};
            dp_q1 <= dp_q[0];
        end
    end

    assign resultado = {dp_a[N-1:0], dp_q};
    assign q         = use_model ? {dp_q[0], dp_q1} : q_force;
    assign ctl       = {start, resta, carga_a, desp, ocupado, fin};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    endtask

    // Expected controls for cycle k after the accepting edge (cycle k lies between edges k-1 and k).
    function automatic logic [5:0] exp_ctl(input int k, input logic [1:0] qv);
        logic s, r, c, d, f, ev;
        ev = (k >= 2) && (k <= 2*N) && (k % 2 == 0);
        s  = (k == 1);
        c  = ev && ((qv == 2'b01) || (qv == 2'b10));
        r  = ev && (qv == 2'b10);
        d  = (k >= 3) && (k <= 2*N + 1) && (k % 2 == 1);
        f  = (k >= 2*N + 3);
        return {s, r, c, d, 1'b1, f};
    endfunction

    task automatic run_op(input int a, input int b, input bit noise, input bit openloop);
        int p;
        op_a = a;
        op_b = b;
        use_model = !openloop;
        p = a * b;
        exp_prod = p[2*N-1:0];
        inicio = 1'b1;
        step();
        inicio = 1'b0;
        for (int k = 1; k <= 2*N + 3; k++) begin
            if (openloop)
                q_force = (k == 2) ? 2'b10 : (k == 4) ? 2'b11 : (k == 6) ? 2'b01 : 2'($urandom);
            if (noise && k <= 2*N + 1) begin
                inicio = 1'($urandom);
                ack    = 1'($urandom);
            end else begin
                inicio = 1'b0;
                ack    = 1'b0;
            end
            #1;
            if (openloop && k == 2*N + 2) exp_prod = resultado;
            chk($sformatf("ctl_k%0d", k), 32'(ctl), 32'(exp_ctl(k, q)));
            if (k < 2*N + 3) step();
        end
        chk("producto", 32'(producto), 32'(exp_prod));
    endtask

    task automatic ack_phase(input int hold, input bit with_inicio);
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_fin", 32'(fin), 32'd1);
            chk("hold_producto", 32'(producto), 32'(exp_prod));
        end
        ack    = 1'b1;
        inicio = with_inicio;
        step();
        ack = 1'b0;
        #1;
        chk("after_ack_ctl", 32'(ctl), 32'd0);
        chk("after_ack_producto", 32'(producto), 32'(exp_prod));
    endtask

    initial begin
        logic [2*N-1:0] c_m6;
        logic [2*N-1:0] c_p16;
        logic [2*N-1:0] c_p9;
        c_m6  = 6'b111010;
        c_p16 = 6'b010000;
        c_p9  = 6'b001001;

        rst_n = 1'b0; inicio = 1'b0; ack = 1'b0; q_force = 2'b00;
        use_model = 1'b1; op_a = 0; op_b = 0;
        step();
        step();
        chk("reset_ctl", 32'(ctl), 32'd0);
        chk("reset_producto", 32'(producto), 32'd0);
        rst_n = 1'b1;
        step();

        // Open-loop trace: q forced to 10, 11, 01 on the three EVALs, random elsewhere.
        run_op(0, 0, 1'b0, 1'b1);
        ack_phase(2, 1'b0);

        run_op(3, -2, 1'b0, 1'b0);
        chk("p_3x-2", 32'(producto), 32'(c_m6));
        ack_phase(10, 1'b0);

        run_op(-4, -4, 1'b0, 1'b0);
        chk("p_-4x-4", 32'(producto), 32'(c_p16));
        ack_phase(1, 1'b1);

        // inicio still high from the ack cycle: accepted on the very next edge.
        run_op(3, 3, 1'b0, 1'b0);
        chk("p_3x3", 32'(producto), 32'(c_p9));
        ack_phase(0, 1'b0);

        // Spurious ack in IDLE.
        ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_ack_ctl", 32'(ctl), 32'd0);
            chk("idle_ack_producto", 32'(producto), 32'(exp_prod));
        end
        ack = 1'b0;

        for (int i = 0; i < 24; i++) begin
            int a, b;
            a = int'($urandom_range(0, 7)) - 4;
            b = int'($urandom_range(0, 7)) - 4;
            run_op(a, b, 1'b1, 1'b0);
            ack_phase(int'($urandom_range(0, 3)), 1'($urandom));
            inicio = 1'b0;
        end

        // Reset during the second EVAL aborts without capturing.
        op_a = 2; op_b = 3; use_model = 1'b1;
        inicio = 1'b1;
        step();
        inicio = 1'b0;
        step();
        step();
        step();
        chk("mid_eval2_ctl", 32'(ctl), 32'(exp_ctl(4, q)));
        rst_n = 1'b0;
        step();
        chk("mid_reset_ctl", 32'(ctl), 32'd0);
        chk("mid_reset_producto", 32'(producto), 32'd0);
        rst_n = 1'b1;
        step();
        chk("post_reset_idle", 32'(ctl), 32'd0);

        run_op(-3, 3, 1'b0, 1'b0);
        ack_phase(0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
